// File: rtl/ext_input_conditioner.sv
// rtl/ext_input_conditioner.sv - per-channel pin synchroniser, counter debouncer and edge pulses
// Optional EXT_INPUT_GLITCH_COUNT_EN adds glitch_count_out with 8-bit saturating abort counters.
module ext_input_conditioner #(
    parameter int   CHANNELS        = 2,
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 18000,
    parameter logic IDLE_LEVEL      = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CHANNELS-1:0]   pins_in,
    output logic [CHANNELS-1:0]   level_out,
    output logic [CHANNELS-1:0]   rise_out,
    output logic [CHANNELS-1:0]   fall_out
`ifdef EXT_INPUT_GLITCH_COUNT_EN
    ,
    output logic [8*CHANNELS-1:0] glitch_count_out
`endif
);

    localparam int             CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {ST_STABLE, ST_PEND} state_t;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        state_t                 r_state;
        state_t                 w_state_nxt;
        logic [CW-1:0]          r_count;
        logic [CW-1:0]          w_count_nxt;
        logic                   r_level;
        logic                   w_level_nxt;
        logic                   r_rise;
        logic                   w_rise_nxt;
        logic                   r_fall;
        logic                   w_fall_nxt;
        logic                   w_abort;
        logic                   w_s;

        assign w_s = r_sync[SYNC_STAGES-1];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_sync <= {SYNC_STAGES{IDLE_LEVEL}};
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], pins_in[g]};
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state <= ST_STABLE;
                r_count <= '0;
                r_level <= IDLE_LEVEL;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_count <= w_count_nxt;
                r_level <= w_level_nxt;
                r_rise  <= w_rise_nxt;
                r_fall  <= w_fall_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_count_nxt = r_count;
            w_level_nxt = r_level;
            w_rise_nxt  = 1'b0;
            w_fall_nxt  = 1'b0;
            w_abort     = 1'b0;
            case (r_state)
                ST_STABLE: begin
                    w_count_nxt = '0;
                    if (w_s != r_level) begin
                        // A one-sample window accepts the new level without passing through PEND.
                        if (DEBOUNCE_CYCLES == 1) begin
                            w_level_nxt = w_s;
                            w_rise_nxt  = w_s;
                            w_fall_nxt  = ~w_s;
                        end else begin
                            w_state_nxt = ST_PEND;
                            w_count_nxt = CW'(1);
                        end
                    end
                end
                ST_PEND: begin
                    if (w_s == r_level) begin
                        w_state_nxt = ST_STABLE;
                        w_count_nxt = '0;
                        w_abort     = 1'b1;
                    end else if (r_count == LAST) begin
                        w_state_nxt = ST_STABLE;
                        w_count_nxt = '0;
                        w_level_nxt = w_s;
                        w_rise_nxt  = w_s;
                        w_fall_nxt  = ~w_s;
                    end else begin
                        w_count_nxt = r_count + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_STABLE;
                    w_count_nxt = '0;
                end
            endcase
        end

        assign level_out[g] = r_level;
        assign rise_out[g]  = r_rise;
        assign fall_out[g]  = r_fall;

`ifdef EXT_INPUT_GLITCH_COUNT_EN
        logic [7:0] r_gcount;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_gcount <= 8'd0;
            end else if (w_abort && (r_gcount != 8'hFF)) begin
                r_gcount <= r_gcount + 8'd1;
            end
        end

        assign glitch_count_out[8*g +: 8] = r_gcount;
`else
        logic w_unused_abort;
        assign w_unused_abort = w_abort;
`endif
    end

endmodule

// File: tb/tb_ext_input_conditioner.sv
// tb/tb_ext_input_conditioner.sv - self-checking bench for ext_input_conditioner
module tb_ext_input_conditioner;

    localparam int SS = 2;
    localparam int DC = 4;
    localparam int HL = SS + DC;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] pins_in = 2'b00;
    logic [1:0] pins1 = 2'b00;
    logic [1:0] level_out, rise_out, fall_out;
    logic [1:0] level1, rise1, fall1;
`ifdef EXT_INPUT_GLITCH_COUNT_EN
    logic [15:0] glitch_count_out;
    logic [15:0] glitch1;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ext_input_conditioner #(.CHANNELS(2), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .IDLE_LEVEL(1'b0)) dut (
        .clk(clk), .reset(reset), .pins_in(pins_in),
        .level_out(level_out), .rise_out(rise_out), .fall_out(fall_out)
`ifdef EXT_INPUT_GLITCH_COUNT_EN
        , .glitch_count_out(glitch_count_out)
`endif
    );

    ext_input_conditioner #(.CHANNELS(2), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(1), .IDLE_LEVEL(1'b0)) dut1 (
        .clk(clk), .reset(reset), .pins_in(pins1),
        .level_out(level1), .rise_out(rise1), .fall_out(fall1)
`ifdef EXT_INPUT_GLITCH_COUNT_EN
        , .glitch_count_out(glitch1)
`endif
    );

    // Reference: the level flips once the last DC synchronised samples all disagree with it.
    logic       ph [2][HL];
    logic [1:0] m_level, m_rise, m_fall;
    int         m_gc [2];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                for (int j = 0; j < HL; j++) ph[c][j] = 1'b0;
                m_gc[c] = 0;
            end
            m_level = 2'b00;
            m_rise  = 2'b00;
            m_fall  = 2'b00;
        end else begin
            for (int c = 0; c < 2; c++) begin
                bit all_diff;
                all_diff = 1'b1;
                for (int j = SS - 1; j <= SS + DC - 2; j++)
                    if (ph[c][j] == m_level[c]) all_diff = 1'b0;
                if (ph[c][SS-1] == m_level[c] && ph[c][SS] != m_level[c] && m_gc[c] < 255)
                    m_gc[c] = m_gc[c] + 1;
                m_rise[c] = 1'b0;
                m_fall[c] = 1'b0;
                if (all_diff) begin
                    m_level[c] = ~m_level[c];
                    m_rise[c]  = m_level[c];
                    m_fall[c]  = ~m_level[c];
                end
                for (int j = HL - 1; j > 0; j--) ph[c][j] = ph[c][j-1];
                ph[c][0] = pins_in[c];
            end
        end
    end

    task automatic step(input logic [1:0] p);
        pins_in = p;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pins_in = 2'b00;
        pins1 = 2'b00;
        step(2'b00);
        step(2'b00);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if (level_out !== 2'b00 || rise_out !== 2'b00 || fall_out !== 2'b00) begin
            failures++;
            $display("FAIL reset_outputs: level=%b rise=%b fall=%b required 00/00/00", level_out, rise_out, fall_out);
        end
`ifdef EXT_INPUT_GLITCH_COUNT_EN
        checks++;
        if (glitch_count_out !== 16'd0) begin
            failures++;
            $display("FAIL reset_glitch: got %h required 0000", glitch_count_out);
        end
`endif
        do_reset();
    endtask

    task automatic test_rise();
        do_reset();
        for (int i = 0; i <= 6; i++) begin
            step(2'b01);
            checks++;
            if (level_out !== ((i >= 5) ? 2'b01 : 2'b00) || rise_out !== ((i == 5) ? 2'b01 : 2'b00) || fall_out !== 2'b00) begin
                failures++;
                $display("FAIL rise_E%0d: level=%b rise=%b fall=%b required level=%b rise=%b fall=00",
                         i, level_out, rise_out, fall_out, (i >= 5) ? 2'b01 : 2'b00, (i == 5) ? 2'b01 : 2'b00);
            end
        end
    endtask

    task automatic test_glitch();
        do_reset();
        for (int i = 0; i < 3; i++) step(2'b01);
        for (int i = 0; i < 8; i++) begin
            step(2'b00);
            checks++;
            if (level_out !== 2'b00 || rise_out !== 2'b00 || fall_out !== 2'b00) begin
                failures++;
                $display("FAIL glitch_cycle%0d: level=%b rise=%b fall=%b required 00/00/00", i, level_out, rise_out, fall_out);
            end
        end
`ifdef EXT_INPUT_GLITCH_COUNT_EN
        checks++;
        if (glitch_count_out !== 16'h0001) begin
            failures++;
            $display("FAIL glitch_count: got %h required 0001", glitch_count_out);
        end
`endif
    endtask

    task automatic test_fall();
        do_reset();
        for (int i = 0; i < 8; i++) step(2'b01);
        for (int i = 0; i <= 6; i++) begin
            step(2'b00);
            checks++;
            if (level_out !== ((i >= 5) ? 2'b00 : 2'b01) || fall_out !== ((i == 5) ? 2'b01 : 2'b00) || rise_out !== 2'b00) begin
                failures++;
                $display("FAIL fall_E%0d: level=%b rise=%b fall=%b required level=%b rise=00 fall=%b",
                         i, level_out, rise_out, fall_out, (i >= 5) ? 2'b00 : 2'b01, (i == 5) ? 2'b01 : 2'b00);
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i <= 6; i++) begin
            step(2'b11);
            checks++;
            if (level_out !== ((i >= 5) ? 2'b11 : 2'b00) || rise_out !== ((i == 5) ? 2'b11 : 2'b00) || fall_out !== 2'b00) begin
                failures++;
                $display("FAIL simul_E%0d: level=%b rise=%b fall=%b required level=%b rise=%b fall=00",
                         i, level_out, rise_out, fall_out, (i >= 5) ? 2'b11 : 2'b00, (i == 5) ? 2'b11 : 2'b00);
            end
        end
    endtask

    task automatic test_reset_mid_pend();
        do_reset();
        for (int i = 0; i < 4; i++) step(2'b01);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (level_out !== 2'b00 || rise_out !== 2'b00 || fall_out !== 2'b00) begin
            failures++;
            $display("FAIL midpend_reset: level=%b rise=%b fall=%b required 00/00/00", level_out, rise_out, fall_out);
        end
        @(negedge clk);
        step(2'b01);
        reset = 1'b0;
        for (int i = 0; i <= 6; i++) begin
            step(2'b01);
            checks++;
            if (level_out !== ((i >= 5) ? 2'b01 : 2'b00) || rise_out !== ((i == 5) ? 2'b01 : 2'b00) || fall_out !== 2'b00) begin
                failures++;
                $display("FAIL midpend_E%0d: level=%b rise=%b fall=%b required level=%b rise=%b fall=00",
                         i, level_out, rise_out, fall_out, (i >= 5) ? 2'b01 : 2'b00, (i == 5) ? 2'b01 : 2'b00);
            end
        end
    endtask

    task automatic test_min_window();
        do_reset();
        pins1 = 2'b01;
        for (int i = 0; i <= 3; i++) begin
            step(2'b00);
            checks++;
            if (level1 !== ((i >= 2) ? 2'b01 : 2'b00) || rise1 !== ((i == 2) ? 2'b01 : 2'b00) || fall1 !== 2'b00) begin
                failures++;
                $display("FAIL minwin_rise_E%0d: level=%b rise=%b fall=%b required level=%b rise=%b fall=00",
                         i, level1, rise1, fall1, (i >= 2) ? 2'b01 : 2'b00, (i == 2) ? 2'b01 : 2'b00);
            end
        end
        pins1 = 2'b00;
        for (int i = 0; i <= 3; i++) begin
            step(2'b00);
            checks++;
            if (level1 !== ((i >= 2) ? 2'b00 : 2'b01) || fall1 !== ((i == 2) ? 2'b01 : 2'b00) || rise1 !== 2'b00) begin
                failures++;
                $display("FAIL minwin_fall_E%0d: level=%b rise=%b fall=%b required level=%b rise=00 fall=%b",
                         i, level1, rise1, fall1, (i >= 2) ? 2'b00 : 2'b01, (i == 2) ? 2'b01 : 2'b00);
            end
        end
    endtask

    task automatic test_random();
        int hold [2];
        logic [1:0] p;
        int bad;
        do_reset();
        hold[0] = 0;
        hold[1] = 0;
        p = 2'b00;
        bad = 0;
        for (int n = 0; n < 2000; n++) begin
            for (int c = 0; c < 2; c++) begin
                if (hold[c] == 0) begin
                    p[c] = 1'($urandom_range(0, 1));
                    hold[c] = $urandom_range(1, 7);
                end
                hold[c]--;
            end
            step(p);
            checks++;
            if (level_out !== m_level || rise_out !== m_rise || fall_out !== m_fall || (rise_out & fall_out) !== 2'b00) begin
                failures++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random_cycle%0d: level=%b rise=%b fall=%b required level=%b rise=%b fall=%b",
                             n, level_out, rise_out, fall_out, m_level, m_rise, m_fall);
            end
`ifdef EXT_INPUT_GLITCH_COUNT_EN
            checks++;
            if (glitch_count_out !== {8'(m_gc[1]), 8'(m_gc[0])}) begin
                failures++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random_glitch%0d: got %h required %h", n, glitch_count_out, {8'(m_gc[1]), 8'(m_gc[0])});
            end
`endif
        end
    endtask

`ifdef EXT_INPUT_GLITCH_COUNT_EN
    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(2'b01);
            step(2'b00);
        end
        for (int i = 0; i < 4; i++) step(2'b00);
        checks++;
        if (glitch_count_out !== 16'h00FF || level_out !== 2'b00) begin
            failures++;
            $display("FAIL saturation: count=%h level=%b required 00ff level=00", glitch_count_out, level_out);
        end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_rise();
        test_glitch();
        test_fall();
        test_simultaneous();
        test_reset_mid_pend();
        test_min_window();
`ifdef EXT_INPUT_GLITCH_COUNT_EN
        test_saturation();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
